// File: rtl/memory_access_pkg.sv
// Shared pipeline definitions: memory geometry, lw/sw flag encodings, op classification.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package memory_access_pkg;

    // Default data-memory geometry: 2^AW words of DW bits.
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    // Register-index and store-counter widths.
    localparam int RD_W   = 5;
    localparam int CNT_W  = 16;

    // Memory-op flag (XM_RDF) and direction (XM_RDF2) encodings.
    localparam logic MEMOP_ON = 1'b1;
    localparam logic DIR_LW   = 1'b1;
    localparam logic DIR_SW   = 1'b0;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_e;

    // The direction bit only matters when the memory-op flag is set.
    function automatic op_e classify(input logic rdf, input logic rdf2);
        op_e op;
        if (rdf != MEMOP_ON)     op = OP_ALU;
        else if (rdf2 == DIR_LW) op = OP_LOAD;
        else                     op = OP_STORE;
        return op;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// EX->MEM request bundle, MEM->WB result bundle and debug read port.
// Latency: n/a (wires only).
// Backpressure: none; the stage accepts one op every cycle.
interface memory_access_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    // EX/MEM side
    logic [DW-1:0] ALUout;
    logic [4:0]    XM_RD;
    logic          XM_RDF;
    logic          XM_RDF2;

    // MEM/WB side
    logic [DW-1:0] MW_ALUout;
    logic [DW-1:0] MW_MemOut;
    logic [4:0]    MW_RD;
    logic          MW_RDF;
    logic          MW_WEN;
    logic [15:0]   st_cnt;

    // Debug peek into data memory
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    // The execute stage (or a bench) drives requests and observes results.
    modport master (
        output ALUout, XM_RD, XM_RDF, XM_RDF2, dbg_addr,
        input  MW_ALUout, MW_MemOut, MW_RD, MW_RDF, MW_WEN, st_cnt, dbg_data
    );

    // The memory-access stage consumes requests and produces results.
    modport slave (
        input  ALUout, XM_RD, XM_RDF, XM_RDF2, dbg_addr,
        output MW_ALUout, MW_MemOut, MW_RD, MW_RDF, MW_WEN, st_cnt, dbg_data
    );
endinterface

// File: rtl/memory_access_dmem.sv
// Data memory: 2^AW x DW words, one synchronous write port, two async read ports.
// Latency: write commits at the edge, visible on reads right after; reads combinational.
// Backpressure: none; a write is accepted every cycle.
module memory_access_dmem #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr0,
    output logic [DW-1:0] o_rdata0,
    input  logic [AW-1:0] i_raddr1,
    output logic [DW-1:0] o_rdata1
);

    logic [DW-1:0] r_mem [2**AW];

    // Reset wipes every word and wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: commits sw to dmem, reads lw data, registers the MEM/WB bundle.
// Latency: exactly one cycle from EX inputs to every MW_* output and st_cnt.
// Backpressure: none; one op is taken every cycle, never stalls.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic clk,
    input  logic rst,
    memory_access_if.slave bus
);

    op_e              w_op;
    logic             w_load;
    logic             w_store;
    logic [DW-1:0]    w_load_data;
    logic [DW-1:0]    w_dbg_data;

    logic [DW-1:0]    r_alu_out;
    logic [DW-1:0]    r_mem_out;
    logic [RD_W-1:0]  r_rd;
    logic             r_rdf;
    logic             r_wen;
    logic [CNT_W-1:0] r_st_cnt;

    assign w_op    = classify(bus.XM_RDF, bus.XM_RDF2);
    assign w_load  = (w_op == OP_LOAD);
    assign w_store = (w_op == OP_STORE);

    // Stores address by XM_RD; loads address by the low ALUout bits.
    memory_access_dmem #(
        .AW (AW),
        .DW (DW)
    ) u_dmem (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_store),
        .i_waddr  (bus.XM_RD[AW-1:0]),
        .i_wdata  (bus.ALUout),
        .i_raddr0 (bus.ALUout[AW-1:0]),
        .o_rdata0 (w_load_data),
        .i_raddr1 (bus.dbg_addr),
        .o_rdata1 (w_dbg_data)
    );

    // MEM/WB register: stores become write-back bubbles, $zero writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= '0;
            r_mem_out <= '0;
            r_rd      <= '0;
            r_rdf     <= 1'b0;
            r_wen     <= 1'b0;
            r_st_cnt  <= '0;
        end else begin
            r_rdf <= w_load;
            if (w_store) begin
                r_alu_out <= '0;
                r_rd      <= '0;
                r_wen     <= 1'b0;
                r_st_cnt  <= r_st_cnt + 1'b1;
            end else begin
                r_alu_out <= bus.ALUout;
                r_rd      <= bus.XM_RD;
                r_wen     <= (bus.XM_RD != '0);
            end
            if (w_load) begin
                r_mem_out <= w_load_data;
            end
        end
    end

    assign bus.MW_ALUout = r_alu_out;
    assign bus.MW_MemOut = r_mem_out;
    assign bus.MW_RD     = r_rd;
    assign bus.MW_RDF    = r_rdf;
    assign bus.MW_WEN    = r_wen;
    assign bus.st_cnt    = r_st_cnt;
    assign bus.dbg_data  = w_dbg_data;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: reset, sw, lw, alu, bubble, back-to-back, st_cnt wrap.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_memory_access;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    memory_access_if #(.AW(5), .DW(32)) bus ();

    memory_access #(.AW(5), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rdf, input logic rdf2, input logic [4:0] rd,
                         input logic [31:0] alu);
        bus.XM_RDF  = rdf;
        bus.XM_RDF2 = rdf2;
        bus.XM_RD   = rd;
        bus.ALUout  = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.dbg_addr = 5'd9;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.MW_ALUout !== 32'd0 || bus.MW_MemOut !== 32'd0 || bus.MW_RD !== 5'd0 ||
            bus.MW_RDF !== 1'b0 || bus.MW_WEN !== 1'b0 || bus.st_cnt !== 16'd0) begin
            $display("FAIL reset_outputs got alu=%h mem=%h rd=%0d rdf=%b wen=%b cnt=%0d want all 0",
                     bus.MW_ALUout, bus.MW_MemOut, bus.MW_RD, bus.MW_RDF, bus.MW_WEN, bus.st_cnt);
            miscompares++;
        end
        vectors++;
        if (bus.dbg_data !== 32'd0) begin
            $display("FAIL reset_mem9 got %h want 0", bus.dbg_data);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_store();
        // Plain store first so the reset has something to wipe.
        drive(1'b1, 1'b0, 5'd9, 32'd1);
        bus.dbg_addr = 5'd9;
        tick();
        vectors++;
        if (bus.dbg_data !== 32'd1 || bus.st_cnt !== 16'd1) begin
            $display("FAIL pre_reset_store got mem9=%h cnt=%0d want 1 1", bus.dbg_data, bus.st_cnt);
            miscompares++;
        end
        // Reset coincident with a store to the same word.
        rst = 1'b1;
        drive(1'b1, 1'b0, 5'd9, 32'd1);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        vectors++;
        if (bus.dbg_data !== 32'd0) begin
            $display("FAIL rst_mid_store_mem9 got %h want 0", bus.dbg_data);
            miscompares++;
        end
        vectors++;
        if (bus.st_cnt !== 16'd0) begin
            $display("FAIL rst_mid_store_cnt got %0d want 0", bus.st_cnt);
            miscompares++;
        end
        vectors++;
        if (bus.MW_ALUout !== 32'd0 || bus.MW_MemOut !== 32'd0 || bus.MW_RD !== 5'd0 ||
            bus.MW_RDF !== 1'b0 || bus.MW_WEN !== 1'b0) begin
            $display("FAIL rst_mid_store_outs got alu=%h mem=%h rd=%0d rdf=%b wen=%b want all 0",
                     bus.MW_ALUout, bus.MW_MemOut, bus.MW_RD, bus.MW_RDF, bus.MW_WEN);
            miscompares++;
        end
    endtask

    task automatic test_store_load();
        drive(1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
        bus.dbg_addr = 5'd3;
        tick();
        vectors++;
        if (bus.dbg_data !== 32'hDEADBEEF) begin
            $display("FAIL sw_dbg got %h want deadbeef", bus.dbg_data);
            miscompares++;
        end
        vectors++;
        if (bus.MW_WEN !== 1'b0 || bus.MW_RD !== 5'd0 || bus.MW_ALUout !== 32'd0 ||
            bus.MW_RDF !== 1'b0) begin
            $display("FAIL sw_wb got wen=%b rd=%0d alu=%h rdf=%b want 0 0 0 0",
                     bus.MW_WEN, bus.MW_RD, bus.MW_ALUout, bus.MW_RDF);
            miscompares++;
        end
        vectors++;
        if (bus.st_cnt !== 16'd1) begin
            $display("FAIL sw_cnt got %0d want 1", bus.st_cnt);
            miscompares++;
        end
        // Load on the very next cycle; bit 5 of the address is beyond AW and ignored.
        drive(1'b1, 1'b1, 5'd8, 32'h00000023);
        tick();
        vectors++;
        if (bus.MW_MemOut !== 32'hDEADBEEF || bus.MW_RDF !== 1'b1 || bus.MW_RD !== 5'd8 ||
            bus.MW_WEN !== 1'b1 || bus.MW_ALUout !== 32'h23) begin
            $display("FAIL lw_after_sw got mem=%h rdf=%b rd=%0d wen=%b alu=%h want deadbeef 1 8 1 23",
                     bus.MW_MemOut, bus.MW_RDF, bus.MW_RD, bus.MW_WEN, bus.MW_ALUout);
            miscompares++;
        end
    endtask

    task automatic test_alu();
        drive(1'b0, 1'b0, 5'd0, 32'd7);
        tick();
        vectors++;
        if (bus.MW_ALUout !== 32'd7 || bus.MW_WEN !== 1'b0 || bus.MW_RDF !== 1'b0) begin
            $display("FAIL alu_rd0 got alu=%h wen=%b rdf=%b want 7 0 0",
                     bus.MW_ALUout, bus.MW_WEN, bus.MW_RDF);
            miscompares++;
        end
        vectors++;
        if (bus.MW_MemOut !== 32'hDEADBEEF) begin
            $display("FAIL memout_hold got %h want deadbeef", bus.MW_MemOut);
            miscompares++;
        end
        drive(1'b0, 1'b1, 5'd5, 32'd7);
        tick();
        vectors++;
        if (bus.MW_ALUout !== 32'd7 || bus.MW_WEN !== 1'b1 || bus.MW_RD !== 5'd5 ||
            bus.MW_RDF !== 1'b0) begin
            $display("FAIL alu_rd5 got alu=%h wen=%b rd=%0d rdf=%b want 7 1 5 0",
                     bus.MW_ALUout, bus.MW_WEN, bus.MW_RD, bus.MW_RDF);
            miscompares++;
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        vectors++;
        if (bus.MW_ALUout !== 32'd0 || bus.MW_WEN !== 1'b0 || bus.MW_RD !== 5'd0 ||
            bus.MW_RDF !== 1'b0 || bus.st_cnt !== 16'd1) begin
            $display("FAIL bubble got alu=%h wen=%b rd=%0d rdf=%b cnt=%0d want 0 0 0 0 1",
                     bus.MW_ALUout, bus.MW_WEN, bus.MW_RD, bus.MW_RDF, bus.st_cnt);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 5'd31, 32'hA5A5A5A5);
        tick();
        drive(1'b1, 1'b0, 5'd0, 32'h00000001);
        tick();
        vectors++;
        if (bus.st_cnt !== 16'd3) begin
            $display("FAIL b2b_cnt got %0d want 3", bus.st_cnt);
            miscompares++;
        end
        drive(1'b1, 1'b1, 5'd31, 32'hFFFFFFFF);
        tick();
        vectors++;
        if (bus.MW_MemOut !== 32'hA5A5A5A5 || bus.MW_RD !== 5'd31 || bus.MW_WEN !== 1'b1) begin
            $display("FAIL b2b_lw31 got mem=%h rd=%0d wen=%b want a5a5a5a5 31 1",
                     bus.MW_MemOut, bus.MW_RD, bus.MW_WEN);
            miscompares++;
        end
        drive(1'b1, 1'b1, 5'd0, 32'h00000000);
        tick();
        vectors++;
        if (bus.MW_MemOut !== 32'd1 || bus.MW_RDF !== 1'b1 || bus.MW_WEN !== 1'b0 ||
            bus.MW_RD !== 5'd0) begin
            $display("FAIL b2b_lw0_rd0 got mem=%h rdf=%b wen=%b rd=%0d want 1 1 0 0",
                     bus.MW_MemOut, bus.MW_RDF, bus.MW_WEN, bus.MW_RD);
            miscompares++;
        end
        drive(1'b1, 1'b1, 5'd2, 32'd20);
        tick();
        vectors++;
        if (bus.MW_MemOut !== 32'd0) begin
            $display("FAIL lw_unwritten got %h want 0", bus.MW_MemOut);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, 5'(i), 32'(i));
            tick();
        end
        vectors++;
        if (bus.st_cnt !== 16'hFFFF) begin
            $display("FAIL wrap_ffff got %h want ffff", bus.st_cnt);
            miscompares++;
        end
        drive(1'b1, 1'b0, 5'd1, 32'd1);
        tick();
        vectors++;
        if (bus.st_cnt !== 16'd0) begin
            $display("FAIL wrap_65536 got %h want 0", bus.st_cnt);
            miscompares++;
        end
        drive(1'b1, 1'b0, 5'd2, 32'd2);
        tick();
        vectors++;
        if (bus.st_cnt !== 16'd1) begin
            $display("FAIL wrap_plus1 got %h want 1", bus.st_cnt);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.dbg_addr = 5'd0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_reset_mid_store();
        test_store_load();
        test_alu();
        test_bubble();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
